// File: rtl/alu_pkg.sv
// Shared ALU opcode/flag definitions and the sequencer state type.
package alu_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_XOR  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  // Bit positions inside the packed {Z,N,C,V} flag nibble.
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/alu_secuenciador_if.sv
// Request, ALU and result bundles of the ALU sequencer; slave = sequencer side.
interface alu_secuenciador_if #(
  parameter int CNT_W = 8
);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_a;
  logic [3:0]       req_b;
  logic [1:0]       req_op;
  logic             req_sweep;

  logic [1:0]       alu_a;
  logic [3:0]       alu_b;
  logic [1:0]       alu_op;
  logic [3:0]       alu_y;
  logic             alu_z;
  logic             alu_n;
  logic             alu_c;
  logic             alu_v;

  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_y;
  logic [3:0]       res_flags;
  logic [1:0]       res_op;
  logic             res_last;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_sweep,
    input  alu_y, alu_z, alu_n, alu_c, alu_v,
    input  res_ready,
    output req_ready,
    output alu_a, alu_b, alu_op,
    output res_valid, res_y, res_flags, res_op, res_last, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_op, req_sweep,
    output alu_y, alu_z, alu_n, alu_c, alu_v,
    output res_ready,
    input  req_ready,
    input  alu_a, alu_b, alu_op,
    input  res_valid, res_y, res_flags, res_op, res_last, op_count
  );

endinterface

// File: rtl/alu_secuenciador.sv
// Sequential front-end for the 4-op ALU: registers operands, captures the
// result one cycle later and returns it over a valid/ready handshake.
module alu_secuenciador
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  alu_secuenciador_if.slave bus
);

  state_e           state_q;
  logic             sweep_q;
  logic [1:0]       alu_a_q;
  logic [3:0]       alu_b_q;
  logic [1:0]       alu_op_q;
  logic             res_valid_q;
  logic [3:0]       res_y_q;
  logic [3:0]       res_flags_q;
  logic [1:0]       res_op_q;
  logic             res_last_q;
  logic [CNT_W-1:0] op_count_q;

  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // and every register uses non-blocking assignment to avoid update races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sweep_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_AND;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_flags_q <= '0;
      res_op_q    <= OP_AND;
      res_last_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            alu_a_q  <= bus.req_a;
            alu_b_q  <= bus.req_b;
            alu_op_q <= bus.req_sweep ? OP_AND : bus.req_op;
            sweep_q  <= bus.req_sweep;
            state_q  <= ST_ISSUE;
          end
        end

        // One full cycle lets the external combinational ALU settle.
        ST_ISSUE: begin
          res_y_q            <= bus.alu_y;
          res_flags_q[FLG_Z] <= bus.alu_z;
          res_flags_q[FLG_N] <= bus.alu_n;
          res_flags_q[FLG_C] <= bus.alu_c;
          res_flags_q[FLG_V] <= bus.alu_v;
          res_op_q           <= alu_op_q;
          res_last_q         <= ~sweep_q | (alu_op_q == OP_SUB);
          res_valid_q        <= 1'b1;
          state_q            <= ST_HOLD;
        end

        ST_HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            op_count_q  <= op_count_q + CNT_W'(1);
            if (sweep_q && (alu_op_q != OP_SUB)) begin
              alu_op_q <= alu_op_q + 2'd1;
              state_q  <= ST_ISSUE;
            end else begin
              state_q  <= ST_IDLE;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE) & ~rst;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_y     = res_y_q;
  assign bus.res_flags = res_flags_q;
  assign bus.res_op    = res_op_q;
  assign bus.res_last  = res_last_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_secuenciador.sv
// Self-checking bench for alu_secuenciador with an ALU stub beside each instance.
module tb_alu_secuenciador;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks    = 0;
  int   failures  = 0;
  int   exp_cnt   = 0;

  alu_secuenciador_if #(.CNT_W(8)) bus1 ();
  alu_secuenciador_if #(.CNT_W(2)) bus2 ();

  alu_secuenciador #(.CNT_W(8)) u_dut      (.clk(clk), .rst(rst), .bus(bus1));
  alu_secuenciador #(.CNT_W(2)) u_dut_wrap (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  // ALU stub: y = b ^ {op, a}; flags = {y==0, y[3], op[0], op[1]}.
  assign bus1.alu_y = bus1.alu_b ^ {bus1.alu_op, bus1.alu_a};
  assign bus1.alu_z = (bus1.alu_y == 4'd0);
  assign bus1.alu_n = bus1.alu_y[3];
  assign bus1.alu_c = bus1.alu_op[0];
  assign bus1.alu_v = bus1.alu_op[1];
  assign bus2.alu_y = bus2.alu_b ^ {bus2.alu_op, bus2.alu_a};
  assign bus2.alu_z = (bus2.alu_y == 4'd0);
  assign bus2.alu_n = bus2.alu_y[3];
  assign bus2.alu_c = bus2.alu_op[0];
  assign bus2.alu_v = bus2.alu_op[1];

  typedef struct {
    logic [1:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] y;
    logic [3:0] flags;
  } vec_t;

  typedef struct {
    logic [3:0] y;
    logic [3:0] flags;
    logic [1:0] op;
    logic       last;
  } res_t;

  vec_t vecs [6];
  res_t exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives one request on bus1 and returns just after the accepting edge.
  task automatic request(input logic [1:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic sweep);
    int g = 0;
    while (!bus1.req_ready && g < 50) begin
      step();
      g++;
    end
    check("req_ready_before_request", {31'd0, bus1.req_ready}, 32'd1);
    bus1.req_a     = a;
    bus1.req_b     = b;
    bus1.req_op    = op;
    bus1.req_sweep = sweep;
    bus1.req_valid = 1'b1;
    step();
    bus1.req_valid = 1'b0;
    bus1.req_a     = 2'($urandom);
    bus1.req_b     = 4'($urandom);
    bus1.req_op    = 2'($urandom);
    bus1.req_sweep = 1'($urandom);
  endtask

  task automatic check_result(input string tag, input logic [3:0] y, input logic [3:0] f,
                              input logic [1:0] op, input logic last);
    check({tag, "_valid"}, {31'd0, bus1.res_valid}, 32'd1);
    check({tag, "_y"},     {28'd0, bus1.res_y},     {28'd0, y});
    check({tag, "_flags"}, {28'd0, bus1.res_flags}, {28'd0, f});
    check({tag, "_op"},    {30'd0, bus1.res_op},    {30'd0, op});
    check({tag, "_last"},  {31'd0, bus1.res_last},  {31'd0, last});
  endtask

  initial begin
    logic [3:0] sw_y [4];
    logic [3:0] sw_f [4];
    logic [1:0] wrap_exp [5];

    vecs[0] = '{a: 2'b01, b: 4'b1010, op: 2'b01, y: 4'b1111, flags: 4'b0110};
    vecs[1] = '{a: 2'b00, b: 4'b0000, op: 2'b00, y: 4'b0000, flags: 4'b1000};
    vecs[2] = '{a: 2'b11, b: 4'b1111, op: 2'b11, y: 4'b0000, flags: 4'b1011};
    vecs[3] = '{a: 2'b10, b: 4'b0011, op: 2'b10, y: 4'b1001, flags: 4'b0101};
    vecs[4] = '{a: 2'b01, b: 4'b0100, op: 2'b00, y: 4'b0101, flags: 4'b0000};
    vecs[5] = '{a: 2'b11, b: 4'b1000, op: 2'b11, y: 4'b0111, flags: 4'b0011};
    sw_y = '{4'b0100, 4'b0000, 4'b1100, 4'b1000};
    sw_f = '{4'b0000, 4'b1010, 4'b0101, 4'b0111};
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    bus1.req_valid = 1'b0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_op = '0;
    bus1.req_sweep = 1'b0; bus1.res_ready = 1'b0;
    bus2.req_valid = 1'b0; bus2.req_a = '0; bus2.req_b = '0; bus2.req_op = '0;
    bus2.req_sweep = 1'b0; bus2.res_ready = 1'b0;

    // Reset state.
    rst = 1'b1;
    step();
    step();
    check("rst_req_ready", {31'd0, bus1.req_ready}, 32'd0);
    check("rst_res_valid", {31'd0, bus1.res_valid}, 32'd0);
    check("rst_alu", {24'd0, bus1.alu_a, bus1.alu_b, bus1.alu_op}, 32'd0);
    check("rst_res", {21'd0, bus1.res_y, bus1.res_flags, bus1.res_op, bus1.res_last}, 32'd0);
    check("rst_op_count", {24'd0, bus1.op_count}, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_req_ready", {31'd0, bus1.req_ready}, 32'd1);

    // Single ops from the vector table, consumer always ready.
    bus1.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      request(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0);
      check("vec_alu_a", {30'd0, bus1.alu_a}, {30'd0, vecs[i].a});
      check("vec_alu_b", {28'd0, bus1.alu_b}, {28'd0, vecs[i].b});
      check("vec_alu_op", {30'd0, bus1.alu_op}, {30'd0, vecs[i].op});
      check("vec_issue_valid", {31'd0, bus1.res_valid}, 32'd0);
      check("vec_issue_ready", {31'd0, bus1.req_ready}, 32'd0);
      step();
      check_result("vec", vecs[i].y, vecs[i].flags, vecs[i].op, 1'b1);
      check("vec_hold_ready", {31'd0, bus1.req_ready}, 32'd0);
      step();
      exp_cnt++;
      check("vec_op_count", {24'd0, bus1.op_count}, exp_cnt % 256);
      check("vec_done_ready", {31'd0, bus1.req_ready}, 32'd1);
      check("vec_done_valid", {31'd0, bus1.res_valid}, 32'd0);
    end

    // Sweep; req_op=11 must be ignored so the first result is opcode 00.
    request(2'b10, 4'b0110, 2'b11, 1'b1);
    check("sweep_first_alu_op", {30'd0, bus1.alu_op}, {30'd0, OP_AND});
    for (int k = 0; k < 4; k++) begin
      step();
      check_result("sweep", sw_y[k], sw_f[k], 2'(k), (k == 3));
      step();
      exp_cnt++;
      check("sweep_op_count", {24'd0, bus1.op_count}, exp_cnt % 256);
      check("sweep_between_valid", {31'd0, bus1.res_valid}, 32'd0);
      check("sweep_req_ready", {31'd0, bus1.req_ready}, {31'd0, (k == 3)});
    end

    // Backpressure: five stalled cycles in HOLD.
    bus1.res_ready = 1'b0;
    request(vecs[5].a, vecs[5].b, vecs[5].op, 1'b0);
    step();
    for (int s = 0; s < 5; s++) begin
      check_result("stall", vecs[5].y, vecs[5].flags, vecs[5].op, 1'b1);
      check("stall_req_ready", {31'd0, bus1.req_ready}, 32'd0);
      check("stall_op_count", {24'd0, bus1.op_count}, exp_cnt % 256);
      step();
    end
    bus1.res_ready = 1'b1;
    step();
    exp_cnt++;
    check("stall_release_count", {24'd0, bus1.op_count}, exp_cnt % 256);
    check("stall_release_valid", {31'd0, bus1.res_valid}, 32'd0);
    check("stall_release_ready", {31'd0, bus1.req_ready}, 32'd1);

    // Reset during the HOLD of the second sweep result.
    request(2'b01, 4'b1100, 2'b00, 1'b1);
    step();
    step();
    exp_cnt++;
    step();
    check("mid_hold_valid", {31'd0, bus1.res_valid}, 32'd1);
    check("mid_hold_op", {30'd0, bus1.res_op}, {30'd0, OP_XOR});
    rst = 1'b1;
    step();
    exp_cnt = 0;
    check("mid_rst_req_ready", {31'd0, bus1.req_ready}, 32'd0);
    check("mid_rst_valid", {31'd0, bus1.res_valid}, 32'd0);
    check("mid_rst_alu", {24'd0, bus1.alu_a, bus1.alu_b, bus1.alu_op}, 32'd0);
    check("mid_rst_res", {21'd0, bus1.res_y, bus1.res_flags, bus1.res_op, bus1.res_last}, 32'd0);
    check("mid_rst_op_count", {24'd0, bus1.op_count}, 32'd0);
    rst = 1'b0;
    step();
    check("after_rst_req_ready", {31'd0, bus1.req_ready}, 32'd1);
    for (int s = 0; s < 6; s++) begin
      check("after_rst_no_result", {31'd0, bus1.res_valid}, 32'd0);
      check("after_rst_count", {24'd0, bus1.op_count}, 32'd0);
      step();
    end

    // Random requests against the behavioural model, random backpressure.
    for (int r = 0; r < 30; r++) begin
      logic [1:0] a, op, o;
      logic [3:0] b, y;
      logic       sweep;
      int         n, g;
      res_t       e;
      a     = 2'($urandom);
      b     = 4'($urandom);
      op    = 2'($urandom);
      sweep = ($urandom_range(0, 3) == 0);
      n     = sweep ? 4 : 1;
      for (int k = 0; k < n; k++) begin
        o = sweep ? 2'(k) : op;
        y = b ^ {o, a};
        e = '{y: y, flags: {(y == 4'd0), y[3], o[0], o[1]}, op: o, last: (k == n - 1)};
        exp_q.push_back(e);
      end
      request(a, b, op, sweep);
      g = 0;
      while (exp_q.size() > 0 && g < 200) begin
        bus1.res_ready = ($urandom_range(0, 3) != 0);
        if (bus1.res_valid && bus1.res_ready) begin
          e = exp_q.pop_front();
          check_result("rand", e.y, e.flags, e.op, e.last);
          step();
          exp_cnt++;
          check("rand_op_count", {24'd0, bus1.op_count}, exp_cnt % 256);
        end else begin
          step();
        end
        g++;
      end
      check("rand_drained", exp_q.size(), 32'd0);
      exp_q.delete();
    end

    // Counter wrap on the 2-bit instance.
    bus2.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int g = 0;
      while (!bus2.req_ready && g < 50) begin
        step();
        g++;
      end
      bus2.req_a     = 2'($urandom);
      bus2.req_b     = 4'($urandom);
      bus2.req_op    = 2'($urandom);
      bus2.req_sweep = 1'b0;
      bus2.req_valid = 1'b1;
      step();
      bus2.req_valid = 1'b0;
      step();
      step();
      check("wrap_op_count", {30'd0, bus2.op_count}, {30'd0, wrap_exp[i]});
      check("wrap_idle", {31'd0, bus2.req_ready}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_secuenciador.md
# alu_secuenciador

Sequential front-end that drives the combinational four-operation ALU (AND, XOR, multiply, subtract; 2-bit A, 4-bit B, 4-bit Y, Z/N/C/V flags). It accepts operation requests over a valid/ready handshake, presents registered operands and opcode to the ALU, captures Y and the flags one cycle later, and returns them over a second valid/ready handshake. A sweep mode issues all four opcodes in order on the same operands, which is used for board-level demos and self-checks.

## Interface
- CNT_W, 8, width of the completed-result counter.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a  in  2  operand A.
- req_b  in  4  operand B.
- req_op  in  2  opcode: 00 AND, 01 XOR, 10 MULT, 11 SUB. Ignored when req_sweep=1.
- req_sweep  in  1  run opcodes 00, 01, 10, 11 in order on the same A and B.
- alu_a  out  2  registered operand A to the ALU.
- alu_b  out  4  registered operand B to the ALU.
- alu_op  out  2  registered opcode to the ALU.
- alu_y  in  4  ALU result.
- alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flags.
- res_valid  out  1  result held and valid.
- res_ready  in  1  consumer accepts the result.
- res_y  out  4  captured result.
- res_flags  out  4  captured flags as {Z,N,C,V}.
- res_op  out  2  opcode that produced the result.
- res_last  out  1  final result of the current request.
- op_count  out  CNT_W  number of completed result handshakes, modulo 2^CNT_W.

## Operation
- States: IDLE, ISSUE, HOLD.
- IDLE
  - req_ready = 1.
  - On req_valid & req_ready: load alu_a←req_a and alu_b←req_b.
  - Load alu_op←(req_sweep ? 00 : req_op). Latch the sweep flag. Go to ISSUE.
- ISSUE (exactly one cycle, ALU settle)
  - At the closing edge: res_y←alu_y, res_flags←{alu_z,alu_n,alu_c,alu_v}, res_op←alu_op.
  - res_last←(~sweep | alu_op==11). Go to HOLD.
- HOLD
  - res_valid = 1. res_* remain stable until the handshake.
  - On res_valid & res_ready: op_count increments.
  - If sweep and alu_op≠11: alu_op←alu_op+1, go to ISSUE. Otherwise go to IDLE.
- req_ready = (state==IDLE) & ~rst. It is not asserted in the same cycle as a HOLD→IDLE handshake.
- alu_a, alu_b and alu_op hold their last value in IDLE.
- op_count wraps from 2^CNT_W−1 to 0 and is otherwise unaffected.
- Reset values: state IDLE; alu_a, alu_b, alu_op, res_y, res_flags, res_op, res_last and op_count all 0; res_valid 0; sweep flag 0. req_ready is 0 while rst=1.
- Reset mid-operation (ISSUE or HOLD):
  - The transaction is dropped and no result handshake occurs.
  - op_count clears.
  - The block is in IDLE with req_ready=1 in the cycle after rst deasserts.
- req_* changes outside an accepted handshake have no effect.

## Timing
- Request accepted at edge E0. ISSUE occupies the cycle E0→E1. res_valid=1 from E1.
- Single-op latency is 1 cycle from acceptance to res_valid, provided res_ready is held high.
- Result handshake at edge E1 or later. The earliest next request is accepted one edge after the return to IDLE.
- Sweep throughput: 2 cycles per result with res_ready held high, so 8 cycles from acceptance to the last handshake.
- res_ready low stalls in HOLD indefinitely. No output changes while stalled.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_AND=2'b00, OP_XOR=2'b01, OP_MULT=2'b10, OP_SUB=2'b11;
  - flag index constants FLG_Z=3, FLG_N=2, FLG_C=1, FLG_V=0;
  - the state enum.
- No sub-module. The ALU is instantiated beside this block at the top level, not inside it.

## Test plan
- Bench ALU stub: y = alu_b ^ {alu_op, alu_a}; flags = {y==0, y[3], alu_op[0], alu_op[1]}.
- Single op: a=01, b=1010, op=01, res_ready=1.
  - Expect res_valid one edge after acceptance, with res_y=1111, res_flags=0110, res_op=01, res_last=1.
  - Expect op_count=1 and req_ready=1 the cycle after.
- Sweep: a=10, b=0110, sweep=1.
  - Expect four results with res_op 00, 01, 10, 11 and res_y 0100, 0000, 1100, 1000.
  - res_last=1 only on the fourth. op_count goes from 0 to 4.
- Backpressure: single op with res_ready=0 for 5 cycles.
  - Expect res_valid held and res_* stable, req_ready=0 and op_count unchanged.
  - Expect the handshake on the first edge with res_ready=1.
- Reset mid-sweep: assert rst during the HOLD of the second result.
  - Expect all outputs at 0, res_valid=0 and op_count=0.
  - Expect req_ready=1 the cycle after rst falls, and no stray results afterwards.
- Counter wrap: CNT_W=2, five single ops.
  - Expect op_count to go 1, 2, 3, 0, 1.
  - req_op must be ignored when sweep=1, e.g. req_op=11 still yields a first result with res_op=00.
